// File: rtl/conv_psum_quant_if.sv
// Output pixel stream from conv_psum_quant toward the output writer.
//   out_vld      : head entry valid (producer)
//   out_rdy      : consumer accepts the head entry (consumer)
//   out_data     : packed quantized pixel, och k at [k*8 +: 8] (producer)
//   out_last_col : head entry is the last column of its row (producer)
interface conv_psum_quant_if #(
  parameter int NUM_OCH = 4
);
  logic                 out_vld;
  logic                 out_rdy;
  logic [NUM_OCH*8-1:0] out_data;
  logic                 out_last_col;

  modport master (
    output out_vld,
    output out_data,
    output out_last_col,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_data,
    input  out_last_col,
    output out_rdy
  );
endinterface

// File: rtl/conv_psum_quant.sv
// Partial-sum accumulator, ReLU/descale/saturate quantizer and output FIFO
// sitting behind the 3x3 MAC kernels of the conv layer.
//   clk, rstn  : clock, asynchronous active-low reset
//   clr        : synchronous soft clear of all state
//   vld_i      : acc_i valid for the current input channel
//   acc_i      : signed MAC results, och k at [k*ACC_W +: ACC_W]
//   pix        : output stream (master side of conv_psum_quant_if)
//   frame_done : one-cycle pulse after the last pixel of a frame is popped
//   ovf_err    : sticky, a pixel was dropped because the FIFO was full
//   busy       : accumulation in progress, quantize pending or FIFO non-empty
module conv_psum_quant #(
  parameter int NUM_OCH     = 4,
  parameter int ACC_W       = 20,
  parameter int PSUM_W      = 32,
  parameter int IFM_CHANNEL = 4,
  parameter int IFM_WIDTH   = 256,
  parameter int IFM_HEIGHT  = 256,
  parameter int SHIFT       = 7,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     vld_i,
  input  logic [NUM_OCH*ACC_W-1:0] acc_i,
  conv_psum_quant_if.master        pix,
  output logic                     frame_done,
  output logic                     ovf_err,
  output logic                     busy
);

  localparam int CHN_W   = (IFM_CHANNEL > 1) ? $clog2(IFM_CHANNEL) : 1;
  localparam int COL_W   = (IFM_WIDTH   > 1) ? $clog2(IFM_WIDTH)   : 1;
  localparam int ROW_W   = (IFM_HEIGHT  > 1) ? $clog2(IFM_HEIGHT)  : 1;
  localparam int PTR_W   = (FIFO_DEPTH  > 1) ? $clog2(FIFO_DEPTH)  : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int DATA_W  = NUM_OCH * 8;
  localparam int ENTRY_W = DATA_W + 2;

  logic        [CHN_W-1:0]  chn_idx;
  logic signed [PSUM_W-1:0] psum [NUM_OCH];
  logic                     pix_done;
  logic        [COL_W-1:0]  col;
  logic        [ROW_W-1:0]  row;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               last_chn;
  logic               last_col;
  logic               frame_last;
  logic               fifo_full;
  logic               fifo_vld;
  logic               pop;
  logic               push_ok;
  logic [DATA_W-1:0]  q;
  logic [PSUM_W-1:0]  relu;
  logic [PSUM_W-1:0]  scaled;
  logic [ENTRY_W-1:0] head;

  assign last_chn   = (chn_idx == CHN_W'(IFM_CHANNEL - 1));
  assign last_col   = (col == COL_W'(IFM_WIDTH - 1));
  assign frame_last = last_col && (row == ROW_W'(IFM_HEIGHT - 1));
  assign fifo_vld   = (count != '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop        = fifo_vld && pix.out_rdy;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push_ok    = pix_done && (!fifo_full || pop);
  assign head       = mem[rd_ptr];

  assign pix.out_vld      = fifo_vld;
  assign pix.out_data     = fifo_vld ? head[DATA_W-1:0] : '0;
  assign pix.out_last_col = fifo_vld && head[DATA_W];
  assign busy             = (chn_idx != '0) || pix_done || fifo_vld;

  // ReLU, descale and saturate the completed accumulators.
  always_comb begin
    q      = '0;
    relu   = '0;
    scaled = '0;
    for (int unsigned k = 0; k < NUM_OCH; k++) begin
      relu   = psum[k][PSUM_W-1] ? '0 : psum[k];
      scaled = relu >> SHIFT;
      q[k*8 +: 8] = (scaled > PSUM_W'(255)) ? 8'hFF : relu[SHIFT+7:SHIFT];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {frame_last, last_col, q};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chn_idx    <= '0;
      pix_done   <= 1'b0;
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      for (int unsigned k = 0; k < NUM_OCH; k++) begin
        psum[k] <= '0;
      end
    end else if (clr) begin
      chn_idx    <= '0;
      pix_done   <= 1'b0;
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      for (int unsigned k = 0; k < NUM_OCH; k++) begin
        psum[k] <= '0;
      end
    end else begin
      if (vld_i) begin
        for (int unsigned k = 0; k < NUM_OCH; k++) begin
          if (chn_idx == '0) begin
            psum[k] <= {{(PSUM_W-ACC_W){acc_i[k*ACC_W+ACC_W-1]}}, acc_i[k*ACC_W +: ACC_W]};
          end else begin
            psum[k] <= psum[k] + {{(PSUM_W-ACC_W){acc_i[k*ACC_W+ACC_W-1]}}, acc_i[k*ACC_W +: ACC_W]};
          end
        end
        chn_idx <= last_chn ? '0 : chn_idx + 1'b1;
      end
      pix_done <= vld_i && last_chn;

      // Position advances on every push attempt so drops keep frame alignment.
      if (pix_done) begin
        if (last_col) begin
          col <= '0;
          row <= (row == ROW_W'(IFM_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);

      frame_done <= pop && head[DATA_W+1];
      if (pix_done && !push_ok) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/conv_psum_quant.md
Name: conv_psum_quant

Overview:
- Sits directly downstream of the four 3x3 MAC kernels in the conv layer.
- Consumes one per-channel partial sum per output channel per valid cycle and accumulates them over all input channels of a pixel.
- Applies ReLU, then descales and saturates each result to 8 bits.
- Buffers the packed 4-channel output pixels in a small FIFO with a valid/ready handshake toward the output writer, and tracks column/row position and frame completion.

Parameters:
- NUM_OCH, 4, output channels handled in parallel (one per MAC).
- ACC_W, 20, width of each signed MAC result.
- PSUM_W, 32, width of each signed channel accumulator.
- IFM_CHANNEL, 4, input channels accumulated per output pixel.
- IFM_WIDTH, 256, pixels per row.
- IFM_HEIGHT, 256, rows per frame.
- SHIFT, 7, descale right-shift amount.
- FIFO_DEPTH, 4, output buffer entries (power of 2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous soft clear of counters, accumulators, FIFO and ovf_err
- vld_i  in  1  acc_i valid for the current input channel
- acc_i  in  NUM_OCH*ACC_W  signed MAC results; och k at [k*ACC_W +: ACC_W]
- out_vld  out  1  FIFO head valid
- out_rdy  in  1  consumer accepts the head entry
- out_data  out  NUM_OCH*8  quantized pixel; och k at [k*8 +: 8]
- out_last_col  out  1  head entry is the last column of its row
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is popped
- ovf_err  out  1  sticky; set when a pixel is dropped because the FIFO was full
- busy  out  1  high when chn_idx!=0, a quantize is pending, or the FIFO is non-empty

Behaviour:
- Reset (rstn low, async) or clr (sync) clears everything to 0: chn_idx, psum[*], the quantize stage, FIFO pointers/count, col/row, out_vld, out_data, out_last_col, frame_done, ovf_err, busy. A reset in mid-pixel discards the partial pixel.
- Accumulate:
  - On each vld_i edge with chn_idx==0: psum[k] <= sign-extend(acc_i[k]).
  - Otherwise: psum[k] <= psum[k] + sign-extend(acc_i[k]).
  - chn_idx increments and wraps to 0 after IFM_CHANNEL-1.
  - Gaps in vld_i are allowed; state is held across them.
- Quantize stage: registered "pixel complete" flag, set on the edge that samples the last channel. On the next edge:
  - r = (psum[k] < 0) ? 0 : psum[k].
  - q = ((r >>> SHIFT) > 255) ? 255 : r[SHIFT+7:SHIFT].
  - The entry {frame_last, last_col, q[*]} is pushed into the FIFO.
- Latency: last channel sampled at edge E, FIFO write at edge E+1, out_vld high from E+1 when the FIFO was empty.
- Push-side position counters:
  - col increments on each push attempt and wraps at IFM_WIDTH-1; row then increments and wraps at IFM_HEIGHT-1.
  - last_col = (col==IFM_WIDTH-1).
  - frame_last = last_col && (row==IFM_HEIGHT-1).
  - Counters advance even when the pixel is dropped, so frame alignment is preserved.
- FIFO is first-word-fall-through:
  - Pop occurs when out_vld && out_rdy.
  - Push while full without a same-cycle pop drops the entry and sets ovf_err.
  - Push and pop in the same cycle while full: both occur and there is no error.
  - out_rdy is ignored while out_vld=0.
- frame_done is a registered pulse, high for exactly one cycle after the edge that pops a frame_last entry.
- The MAC side cannot be stalled; there is no ready output toward the MACs.

Test Plan:
- Accumulate and descale: IFM_CHANNEL=4, SHIFT=7; och0 receives 100, 200, 300, 400 (sum 1000) -> out_data[7:0]=7, with out_vld rising one edge after the 4th vld_i edge.
- ReLU and saturation: sums of -500, 32639, 32640 and 40000 on och0..3 -> out_data bytes 0, 254, 255, 255.
- Gapped input: 4 channels with 3 idle cycles between each; sign-extended -1 on every channel for och1 -> psum=-4, byte 0; chn_idx returns to 0 after the pixel.
- Overflow: out_rdy=0, 5 pixels pushed, FIFO_DEPTH=4 -> 4 entries held, ovf_err=1. Then out_rdy=1 -> pixels 0..3 pop in order and ovf_err stays 1 until clr.
- Frame tracking: IFM_WIDTH=4, IFM_HEIGHT=2, out_rdy=1, 16 pixels pushed -> out_last_col on pixels 3, 7, 11, 15; frame_done pulses once after pixels 7 and 15; pixel 8 is row 0, col 0.
- Reset mid-operation: rstn low after 2 of 4 channels -> all outputs 0 asynchronously. After release, 4 fresh channels each of 128 -> byte 4, with no contribution from the earlier partial sum.
